// File: rtl/jk_bank_driver_if.sv
// Target/bank bundle between a sequence source, jk_bank_driver and a JK flip-flop bank.
// The driver uses the slave view; the source/bank side uses the master view.
interface jk_bank_driver_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
);
  logic          tgt_valid;
  logic          tgt_ready;
  logic [N-1:0]  tgt_data;
  logic          tgt_clr;
  logic [N-1:0]  q_fb;
  logic [N-1:0]  j;
  logic [N-1:0]  k;
  logic          jk_rst;
  logic          done_valid;
  logic          mismatch;
  logic [CW-1:0] err_count;

  modport master (
    output tgt_valid, tgt_data, tgt_clr, q_fb,
    input  tgt_ready, j, k, jk_rst, done_valid, mismatch, err_count
  );

  modport slave (
    input  tgt_valid, tgt_data, tgt_clr, q_fb,
    output tgt_ready, j, k, jk_rst, done_valid, mismatch, err_count
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank to a requested word for one cycle, then reads it back
// and keeps a saturating count of mismatches.
module jk_bank_driver #(
  parameter int unsigned N       = 4,
  parameter int unsigned CW      = 8,
  parameter bit          DC_MODE = 1'b0
) (
  input logic             clk,
  input logic             reset,
  jk_bank_driver_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  localparam logic [N-1:0] DcMask = {N{DC_MODE}};

  state_e        state_q, state_d;
  logic [N-1:0]  tgt_q, tgt_d;
  logic [N-1:0]  j_q, j_d;
  logic [N-1:0]  k_q, k_d;
  logic          jk_rst_q, jk_rst_d;
  logic          done_q, done_d;
  logic          mism_q, mism_d;
  logic [CW-1:0] err_q, err_d;
  logic          ready;
  logic          accept;

  assign ready  = (state_q == StIdle) && !reset;
  assign accept = bus.tgt_valid && ready;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    j_d      = j_q;
    k_d      = k_q;
    jk_rst_d = jk_rst_q;
    done_d   = 1'b0;
    mism_d   = mism_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        j_d      = '0;
        k_d      = '0;
        jk_rst_d = 1'b0;
        if (accept) begin
          state_d = StDrive;
          if (bus.tgt_clr) begin
            tgt_d    = '0;
            jk_rst_d = 1'b1;
          end else begin
            // Excitation from the live bank value; don't-care bits take DcMask.
            tgt_d = bus.tgt_data;
            j_d   = (~bus.q_fb & bus.tgt_data) | (bus.q_fb & DcMask);
            k_d   = (bus.q_fb & ~bus.tgt_data) | (~bus.q_fb & DcMask);
          end
        end
      end
      StDrive: begin
        j_d      = '0;
        k_d      = '0;
        jk_rst_d = 1'b0;
        state_d  = StCheck;
      end
      StCheck: begin
        done_d = 1'b1;
        mism_d = (bus.q_fb != tgt_q);
        if (mism_d && (err_q != '1)) begin
          err_d = err_q + CW'(1);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      jk_rst_q <= 1'b0;
      done_q   <= 1'b0;
      mism_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      jk_rst_q <= jk_rst_d;
      done_q   <= done_d;
      mism_q   <= mism_d;
      err_q    <= err_d;
    end
  end

  assign bus.tgt_ready  = ready;
  assign bus.j          = j_q;
  assign bus.k          = k_q;
  assign bus.jk_rst     = jk_rst_q;
  assign bus.done_valid = done_q;
  assign bus.mismatch   = mism_q;
  assign bus.err_count  = err_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// Two drivers (DC_MODE 0 / CW 8 and DC_MODE 1 / CW 2) run in lockstep, each on its own
// behavioural JK bank that can be disturbed or given stuck-at-0 bits.
module tb_jk_bank_driver;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jk_bank_driver_if #(.N(4), .CW(8)) ia ();
  jk_bank_driver_if #(.N(4), .CW(2)) ib ();

  jk_bank_driver #(.N(4), .CW(8), .DC_MODE(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  jk_bank_driver #(.N(4), .CW(2), .DC_MODE(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] bank_a, bank_b;
  logic [3:0] stuck = '0;
  logic       dist_req = 1'b0;
  logic [3:0] dist_val = '0;

  function automatic logic [3:0] bank_step(input logic [3:0] q, input logic [3:0] j,
                                           input logic [3:0] k);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      bank_a <= '0;
      bank_b <= '0;
    end else if (dist_req) begin
      bank_a <= dist_val & ~stuck;
      bank_b <= dist_val & ~stuck;
    end else begin
      bank_a <= ia.jk_rst ? 4'b0000 : (bank_step(bank_a, ia.j, ia.k) & ~stuck);
      bank_b <= ib.jk_rst ? 4'b0000 : (bank_step(bank_b, ib.j, ib.k) & ~stuck);
    end
  end

  assign ia.q_fb = bank_a;
  assign ib.q_fb = bank_b;

  // Accept/done monitor for the held-valid sequence.
  logic       mon_en = 1'b0;
  int         acc_cyc[$];
  logic [3:0] acc_dat[$];
  int         done_cnt = 0;
  always @(posedge clk) begin
    if (mon_en && ia.tgt_valid && ia.tgt_ready) begin
      acc_cyc.push_back(cyc);
      acc_dat.push_back(ia.tgt_data);
    end
    if (mon_en && ia.done_valid) done_cnt <= done_cnt + 1;
  end

  // JK excitation table; x resolved to dc.
  function automatic logic [7:0] exc(input logic [3:0] q, input logic [3:0] t, input bit dc);
    logic [3:0] jj, kk;
    for (int i = 0; i < 4; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin jj[i] = 1'b0; kk[i] = dc;   end
        2'b01:   begin jj[i] = 1'b1; kk[i] = dc;   end
        2'b10:   begin jj[i] = dc;   kk[i] = 1'b1; end
        default: begin jj[i] = dc;   kk[i] = 1'b0; end
      endcase
    end
    return {jj, kk};
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic c);
    ia.tgt_valid = v; ia.tgt_data = d; ia.tgt_clr = c;
    ib.tgt_valid = v; ib.tgt_data = d; ib.tgt_clr = c;
  endtask

  task automatic run_xact(input logic [3:0] t, input logic c,
                          input logic [3:0] eja, input logic [3:0] eka,
                          input logic [3:0] ejb, input logic [3:0] ekb,
                          input logic emm, input int unsigned ea, input int unsigned eb);
    int w = 0;
    drive(1'b1, t, c);
    while (!(ia.tgt_ready && ib.tgt_ready) && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) chk("ready_timeout", 0, 1);
    tick();  // accept edge
    drive(1'b0, 4'b0000, 1'b0);
    chk("a_j", ia.j, eja);        chk("a_k", ia.k, eka);
    chk("b_j", ib.j, ejb);        chk("b_k", ib.k, ekb);
    chk("a_jk_rst", ia.jk_rst, c); chk("b_jk_rst", ib.jk_rst, c);
    chk("a_ready_drive", ia.tgt_ready, 0);
    tick();  // bank updated
    chk("a_jk_idle", {ia.j, ia.k, 3'b000, ia.jk_rst}, 0);
    chk("b_jk_idle", {ib.j, ib.k, 3'b000, ib.jk_rst}, 0);
    chk("a_done_early", ia.done_valid, 0);
    chk("a_ready_check", ia.tgt_ready, 0);
    tick();  // check result
    chk("a_done", ia.done_valid, 1); chk("b_done", ib.done_valid, 1);
    chk("a_mismatch", ia.mismatch, emm); chk("b_mismatch", ib.mismatch, emm);
    chk("a_err", ia.err_count, ea); chk("b_err", ib.err_count, eb);
    tick();
    chk("a_done_low", ia.done_valid, 0); chk("b_done_low", ib.done_valid, 0);
    chk("a_mismatch_held", ia.mismatch, emm);
    chk("a_ready_back", ia.tgt_ready, 1);
  endtask

  typedef struct {
    logic [3:0] t;
    logic       c;
    logic [3:0] stk;
    logic [3:0] ja, ka, jb, kb;
    logic       mm;
    int unsigned ea, eb;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int unsigned ea_m, eb_m;
    logic [3:0] tg[3];
    logic [7:0] xa, xb;
    logic [3:0] t, fin, tl;
    logic       c, mm;

    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned ea_m, eb_m;
    logic [3:0] tg[3];
    logic [7:0] xa, xb;
    logic [3:0] t, fin, tl;
    logic       c, mm;
    int         w;

    //        t        c     stuck    ja       ka       jb       kb       mm    ea eb
    tbl[0] = '{4'b1010, 1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1111, 1'b0, 0, 0};
    tbl[1] = '{4'b0110, 1'b0, 4'b0000, 4'b0100, 4'b1000, 4'b1110, 4'b1101, 1'b0, 0, 0};
    tbl[2] = '{4'b1111, 1'b0, 4'b0000, 4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b0, 0, 0};
    tbl[3] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0};
    tbl[4] = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 1, 1};
    tbl[5] = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 2, 2};
    tbl[6] = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 3, 3};
    tbl[7] = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 4, 3};
    tbl[8] = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b1, 5, 3};
    tbl[9] = '{4'b1001, 1'b0, 4'b0000, 4'b1001, 4'b0000, 4'b1001, 4'b1111, 1'b0, 5, 3};

    drive(1'b0, 4'b0000, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_a_outputs", {ia.j, ia.k, ia.jk_rst, ia.done_valid, ia.mismatch}, 0);
    chk("rst_b_outputs", {ib.j, ib.k, ib.jk_rst, ib.done_valid, ib.mismatch}, 0);
    chk("rst_a_err", ia.err_count, 0);
    chk("rst_ready_low", ia.tgt_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", ia.tgt_ready, 1);
    chk("rst_bank", bank_a, 0);

    for (int i = 0; i < 10; i++) begin
      stuck = tbl[i].stk;
      run_xact(tbl[i].t, tbl[i].c, tbl[i].ja, tbl[i].ka, tbl[i].jb, tbl[i].kb,
               tbl[i].mm, tbl[i].ea, tbl[i].eb);
      chk("tbl_bank_a", bank_a, tbl[i].c ? 4'b0000 : (tbl[i].t & ~tbl[i].stk));
    end
    ea_m = tbl[9].ea;
    eb_m = tbl[9].eb;

    // Valid held high across three back-to-back targets.
    tg[0] = 4'b0011; tg[1] = 4'b1100; tg[2] = 4'b0101;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, tg[i], 1'b0);
      w = 0;
      while (!ia.tgt_ready && w < 10) begin
        tick();
        w++;
      end
      if (w >= 10) chk("held_ready_timeout", 0, 1);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0);
    repeat (4) tick();
    mon_en = 1'b0;
    chk("held_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("held_data", acc_dat[i], tg[i]);
      chk("held_gap01", acc_cyc[1] - acc_cyc[0], 3);
      chk("held_gap12", acc_cyc[2] - acc_cyc[1], 3);
    end
    chk("held_dones", done_cnt, 3);
    chk("held_bank", bank_a, 4'b0101);
    chk("held_err", ia.err_count, ea_m);

    // Random targets, clears, stuck bits and external disturbances.
    for (int n = 0; n < 40; n++) begin
      stuck = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 1) == 1) begin
        dist_val = 4'($urandom);
        dist_req = 1'b1;
        tick();
        dist_req = 1'b0;
      end
      t  = 4'($urandom);
      c  = ($urandom_range(0, 5) == 0);
      xa = c ? 8'h00 : exc(bank_a, t, 1'b0);
      xb = c ? 8'h00 : exc(bank_b, t, 1'b1);
      tl  = c ? 4'b0000 : t;
      fin = c ? 4'b0000 : (t & ~stuck);
      mm  = (fin != tl);
      if (mm) begin
        if (ea_m < 255) ea_m++;
        if (eb_m < 3) eb_m++;
      end
      run_xact(t, c, xa[7:4], xa[3:0], xb[7:4], xb[3:0], mm, ea_m, eb_m);
      chk("rnd_bank_b", bank_b, fin);
    end

    // Reset while in DRIVE aborts a transaction that would have mismatched.
    stuck = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stuck = 4'b0001;
    drive(1'b1, 4'b0001, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b0);
    chk("abort_drive_j", ia.j, 4'b0001);
    reset = 1'b1;
    tick();
    chk("abort_a_jk", {ia.j, ia.k, 3'b000, ia.jk_rst}, 0);
    chk("abort_b_jk", {ib.j, ib.k, 3'b000, ib.jk_rst}, 0);
    chk("abort_ready_in_reset", ia.tgt_ready, 0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", ia.tgt_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", ia.done_valid | ib.done_valid, 0);
      chk("abort_err_a", ia.err_count, 0);
      chk("abort_err_b", ib.err_count, 0);
    end
    stuck = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
